crtc_6845: RTL

- HD6845-class CRT controller (type-0 behaviour subset) that sits directly upstream of the gate array.
- Generates HSYNC, VSYNC and DISPEN for the gate array's sync/interrupt and video-control logic, plus MA/RA refresh-and-video addresses for the DRAM address mux.
- Clocked by the gate array's 1 MHz CCLK.
- CPU programs it through an index/data register pair.

---
 rtl/crtc_6845.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/crtc_6845.sv
// crtc_6845: HD6845-class CRT controller (type-0 subset) producing HSYNC/VSYNC/DISPEN and MA/RA.
// Latency: all outputs registered; register writes act from the following edge, reads return one edge later.
// Backpressure: none; free-running on CCLK, every bus access completes in the cycle it is presented.
module crtc_6845 #(
    parameter int MA_W = 14,
    parameter int RA_W = 5
) (
    input  logic            CCLK,
    input  logic            RESET_n,
    input  logic            CS_n,
    input  logic            RS,
    input  logic            RW,
    input  logic [7:0]      D_IN,
    output logic [7:0]      D_OUT,
    output logic            HSYNC,
    output logic            VSYNC,
    output logic            DISPEN,
    output logic [MA_W-1:0] MA,
    output logic [RA_W-1:0] RA
);

    typedef enum logic {ST_NORMAL = 1'b0, ST_ADJUST = 1'b1} state_t;

    // Register file held at its stored widths; R8/R10/R11 are kept only for the CPU's benefit.
    typedef struct packed {
        logic [7:0] r0;
        logic [7:0] r1;
        logic [7:0] r2;
        logic [7:0] r3;
        logic [6:0] r4;
        logic [4:0] r5;
        logic [6:0] r6;
        logic [6:0] r7;
        logic [1:0] r8;
        logic [4:0] r9;
        logic [6:0] r10;
        logic [4:0] r11;
        logic [5:0] r12;
        logic [7:0] r13;
        logic [5:0] r14;
        logic [7:0] r15;
    } regs_t;

    regs_t           regs_q, regs_d;
    logic [4:0]      idx_q, idx_d;
    logic [7:0]      dout_q, dout_d;
    logic [7:0]      hcc_q, hcc_d;
    logic [4:0]      vlc_q, vlc_d;
    logic [6:0]      vcc_q, vcc_d;
    logic [4:0]      adj_q, adj_d;
    state_t          st_q, st_d;
    logic [MA_W-1:0] ma_q, ma_d;
    logic [MA_W-1:0] row_q, row_d;
    logic [3:0]      hs_cnt_q, hs_cnt_d;
    logic [4:0]      vs_cnt_q, vs_cnt_d;
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic            dispen_q, dispen_d;

    logic            line_end;
    logic            frame_start;
    logic [MA_W-1:0] ma_start;
    logic            unused_regs;

    assign unused_regs = ^{regs_q.r8, regs_q.r10, regs_q.r11};
    assign ma_start    = MA_W'({regs_q.r12, regs_q.r13});

    // CPU side: index/data register writes and registered read-back of R12-R15.
    always_comb begin
        regs_d = regs_q;
        idx_d  = idx_q;
        dout_d = dout_q;
        if (!CS_n && !RW) begin
            if (!RS) begin
                idx_d = D_IN[4:0];
            end else begin
                case (idx_q)
                    5'd0:    regs_d.r0  = D_IN;
                    5'd1:    regs_d.r1  = D_IN;
                    5'd2:    regs_d.r2  = D_IN;
                    5'd3:    regs_d.r3  = D_IN;
                    5'd4:    regs_d.r4  = D_IN[6:0];
                    5'd5:    regs_d.r5  = D_IN[4:0];
                    5'd6:    regs_d.r6  = D_IN[6:0];
                    5'd7:    regs_d.r7  = D_IN[6:0];
                    5'd8:    regs_d.r8  = D_IN[1:0];
                    5'd9:    regs_d.r9  = D_IN[4:0];
                    5'd10:   regs_d.r10 = D_IN[6:0];
                    5'd11:   regs_d.r11 = D_IN[4:0];
                    5'd12:   regs_d.r12 = D_IN[5:0];
                    5'd13:   regs_d.r13 = D_IN;
                    5'd14:   regs_d.r14 = D_IN[5:0];
                    5'd15:   regs_d.r15 = D_IN;
                    default: regs_d = regs_q;
                endcase
            end
        end else if (!CS_n && RW) begin
            if (!RS) begin
                dout_d = 8'h00;
            end else begin
                case (idx_q)
                    5'd12:   dout_d = {2'b00, regs_q.r12};
                    5'd13:   dout_d = regs_q.r13;
                    5'd14:   dout_d = {2'b00, regs_q.r14};
                    5'd15:   dout_d = regs_q.r15;
                    default: dout_d = 8'h00;
                endcase
            end
        end
    end

    // Character/raster/row counters and the NORMAL/ADJUST frame sequencer.
    always_comb begin
        line_end    = (hcc_q == regs_q.r0);
        hcc_d       = line_end ? 8'd0 : hcc_q + 8'd1;
        vlc_d       = vlc_q;
        vcc_d       = vcc_q;
        adj_d       = adj_q;
        st_d        = st_q;
        frame_start = 1'b0;
        if (line_end) begin
            if (st_q == ST_NORMAL) begin
                if (vlc_q == regs_q.r9) begin
                    vlc_d = 5'd0;
                    if (vcc_q == regs_q.r4) begin
                        if (regs_q.r5 == 5'd0) begin
                            frame_start = 1'b1;
                        end else begin
                            st_d  = ST_ADJUST;
                            adj_d = 5'd0;
                        end
                    end else begin
                        vcc_d = vcc_q + 7'd1;
                    end
                end else begin
                    vlc_d = vlc_q + 5'd1;
                end
            end else if (adj_q == regs_q.r5 - 5'd1) begin
                frame_start = 1'b1;
            end else begin
                adj_d = adj_q + 5'd1;
                vlc_d = vlc_q + 5'd1;
            end
        end
        if (frame_start) begin
            vcc_d = 7'd0;
            vlc_d = 5'd0;
            st_d  = ST_NORMAL;
        end
    end

    // Video address: runs every cycle, snapshots the row start on the last raster, reloads at line end.
    always_comb begin
        ma_d  = ma_q + MA_W'(1);
        row_d = row_q;
        if (hcc_q == regs_q.r1 && vlc_q == regs_q.r9) begin
            row_d = ma_q;
        end
        if (frame_start) begin
            ma_d  = ma_start;
            row_d = ma_start;
        end else if (line_end) begin
            ma_d = row_q;
        end
    end

    // Sync pulse generators and display enable, decoded from the next counter state.
    always_comb begin
        hsync_d  = 1'b0;
        hs_cnt_d = 4'd0;
        if (hsync_q && hs_cnt_q != 4'd1) begin
            hsync_d  = 1'b1;
            hs_cnt_d = hs_cnt_q - 4'd1;
        end else if (hcc_d == regs_q.r2 && regs_q.r3[3:0] != 4'd0) begin
            hsync_d  = 1'b1;
            hs_cnt_d = regs_q.r3[3:0];
        end

        vsync_d  = vsync_q;
        vs_cnt_d = vs_cnt_q;
        if (vsync_q) begin
            if (line_end) begin
                if (vs_cnt_q == 5'd1) begin
                    vsync_d  = 1'b0;
                    vs_cnt_d = 5'd0;
                end else begin
                    vs_cnt_d = vs_cnt_q - 5'd1;
                end
            end
        end else if (line_end && st_d == ST_NORMAL && vcc_d == regs_q.r7 && vlc_d == 5'd0) begin
            vsync_d  = 1'b1;
            vs_cnt_d = (regs_q.r3[7:4] == 4'd0) ? 5'd16 : {1'b0, regs_q.r3[7:4]};
        end

        dispen_d = (hcc_d < regs_q.r1) && (vcc_d < regs_q.r6) && (st_d == ST_NORMAL);
    end

    // State update with synchronous active-low reset.
    always_ff @(posedge CCLK) begin
        if (!RESET_n) begin
            regs_q   <= '0;
            idx_q    <= 5'd0;
            dout_q   <= 8'h00;
            hcc_q    <= 8'd0;
            vlc_q    <= 5'd0;
            vcc_q    <= 7'd0;
            adj_q    <= 5'd0;
            st_q     <= ST_NORMAL;
            ma_q     <= '0;
            row_q    <= '0;
            hs_cnt_q <= 4'd0;
            vs_cnt_q <= 5'd0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            dispen_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            idx_q    <= idx_d;
            dout_q   <= dout_d;
            hcc_q    <= hcc_d;
            vlc_q    <= vlc_d;
            vcc_q    <= vcc_d;
            adj_q    <= adj_d;
            st_q     <= st_d;
            ma_q     <= ma_d;
            row_q    <= row_d;
            hs_cnt_q <= hs_cnt_d;
            vs_cnt_q <= vs_cnt_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            dispen_q <= dispen_d;
        end
    end

    assign D_OUT  = dout_q;
    assign HSYNC  = hsync_q;
    assign VSYNC  = vsync_q;
    assign DISPEN = dispen_q;
    assign MA     = ma_q;
    assign RA     = RA_W'(vlc_q);

endmodule
